fb_mem_scheduler: RTL and testbench

//  Owns the single port of the packed RGB framebuffer RAM (3 bit-planes, DATA_WIDTH vertically adjacent pixels/word).

---
 rtl/fb_mem_pkg.sv | 33 +++
 rtl/fb_clear_engine.sv | 42 ++++
 rtl/fb_mem_scheduler.sv | 155 +++++++++++++++
 tb/tb_fb_mem_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_mem_pkg.sv
// Shared state encoding and helpers for the framebuffer port scheduler.
package fb_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAPT,
        RDWAIT,
        MERGE,
        WRITE,
        CLEAR
    } fb_state_t;

    function automatic int unsigned fb_depth(input int unsigned memory_h,
                                             input int unsigned word_rows);
        return memory_h * word_rows;
    endfunction

    function automatic int unsigned fb_sel_w(input int unsigned data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

    // Words up to 32 pixels wide; callers cast the result back to DATA_WIDTH.
    function automatic logic [31:0] fb_bit_insert(input logic [31:0] word,
                                                  input logic [4:0]  sel,
                                                  input logic        value);
        logic [31:0] w;
        w      = word;
        w[sel] = value;
        return w;
    endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Framebuffer clear pointer: arms on clear_req, steps once per written word,
// holds its position while paused and pulses done after the last word.
module fb_clear_engine #(
    parameter int unsigned DEPTH      = 4800,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    input  logic                  advance,
    output logic                  active,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  last,
    output logic                  done
);

    assign last = (ptr == ADDR_WIDTH'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            ptr    <= '0;
            done   <= 1'b0;
        end else begin
            done <= advance && last;
            if (!active) begin
                if (clear_req) begin
                    active <= 1'b1;
                    ptr    <= '0;
                end
            end else if (advance) begin
                if (last) begin
                    active <= 1'b0;
                    ptr    <= '0;
                end else begin
                    ptr <= ptr + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fb_mem_scheduler.sv
// Single-port framebuffer arbiter: scan-out owns the RAM in active video, blanking
// applies FIFO pixel writes by read-modify-write. Optional clear: FB_CLEAR_EN.
module fb_mem_scheduler
    import fb_mem_pkg::*;
#(
    parameter int unsigned MEMORY_H   = 80,
    parameter int unsigned WORD_ROWS  = 60,
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned RD_LATENCY = 2,
    localparam int unsigned SEL_W     = fb_sel_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  display_on,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [ADDR_WIDTH-1:0] fifo_addr,
    input  logic [SEL_W-1:0]      fifo_bitsel,
    input  logic [2:0]            fifo_rgb,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata_r,
    output logic [DATA_WIDTH-1:0] mem_wdata_g,
    output logic [DATA_WIDTH-1:0] mem_wdata_b,
    input  logic [DATA_WIDTH-1:0] mem_rdata_r,
    input  logic [DATA_WIDTH-1:0] mem_rdata_g,
    input  logic [DATA_WIDTH-1:0] mem_rdata_b,
    output logic                  busy,
    output logic [7:0]            err_count,
    input  logic                  clear_req,
    output logic                  clear_done
);

    localparam int unsigned DEPTH    = fb_depth(MEMORY_H, WORD_ROWS);
    localparam logic [2:0]  LAT_LAST = 3'(RD_LATENCY - 1);

    fb_state_t             state, state_nxt;
    logic                  pending_valid;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [SEL_W-1:0]      bitsel_q;
    logic [2:0]            rgb_q;
    logic [2:0]            lat_cnt;
    logic [DATA_WIDTH-1:0] merged_r, merged_g, merged_b;
    logic                  entry_bad;
    logic                  clear_active, clear_advance, clr_last;
    logic [ADDR_WIDTH-1:0] clr_ptr;

    assign entry_bad = (32'(fifo_addr) >= DEPTH) || (32'(fifo_bitsel) >= DATA_WIDTH);

    // Clear outranks a held entry so the retried pixel lands on the cleared frame.
    function automatic fb_state_t dispatch(input logic clr, input logic pend, input logic empty);
        if (clr)         return CLEAR;
        else if (pend)   return RDWAIT;
        else if (!empty) return POP;
        else             return IDLE;
    endfunction

    always_comb begin
        state_nxt     = state;
        fifo_rd_en    = 1'b0;
        mem_we        = 1'b0;
        clear_advance = 1'b0;
        if (display_on) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:   state_nxt = dispatch(clear_active, pending_valid, fifo_empty);
                POP: begin
                    fifo_rd_en = !fifo_empty;
                    state_nxt  = fifo_empty ? IDLE : CAPT;
                end
                CAPT:   state_nxt = entry_bad ? IDLE : RDWAIT;
                RDWAIT: if (lat_cnt == LAT_LAST) state_nxt = MERGE;
                MERGE:  state_nxt = WRITE;
                // Dispatch straight from WRITE keeps one pixel per 4+RD_LATENCY cycles.
                WRITE: begin
                    mem_we    = 1'b1;
                    state_nxt = dispatch(clear_active, 1'b0, fifo_empty);
                end
                CLEAR: begin
                    mem_we        = 1'b1;
                    clear_advance = 1'b1;
                    state_nxt     = clr_last ? IDLE : CLEAR;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pending_valid <= 1'b0;
            addr_q        <= '0;
            bitsel_q      <= '0;
            rgb_q         <= '0;
            lat_cnt       <= '0;
            merged_r      <= '0;
            merged_g      <= '0;
            merged_b      <= '0;
            err_count     <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= (state == RDWAIT && state_nxt == RDWAIT) ? lat_cnt + 3'd1 : '0;
            if (state == CAPT) begin
                addr_q   <= fifo_addr;
                bitsel_q <= fifo_bitsel;
                rgb_q    <= fifo_rgb;
                if (entry_bad) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end else begin
                    pending_valid <= 1'b1;
                end
            end
            if (state == MERGE) begin
                merged_r <= DATA_WIDTH'(fb_bit_insert(32'(mem_rdata_r), 5'(bitsel_q), rgb_q[2]));
                merged_g <= DATA_WIDTH'(fb_bit_insert(32'(mem_rdata_g), 5'(bitsel_q), rgb_q[1]));
                merged_b <= DATA_WIDTH'(fb_bit_insert(32'(mem_rdata_b), 5'(bitsel_q), rgb_q[0]));
            end
            if (mem_we && state == WRITE) pending_valid <= 1'b0;
        end
    end

    assign mem_addr    = display_on ? disp_addr : ((state == CLEAR) ? clr_ptr : addr_q);
    assign mem_wdata_r = (state == CLEAR) ? '0 : merged_r;
    assign mem_wdata_g = (state == CLEAR) ? '0 : merged_g;
    assign mem_wdata_b = (state == CLEAR) ? '0 : merged_b;
    assign busy        = pending_valid || clear_active || state == POP || state == CAPT;

`ifdef FB_CLEAR_EN
    fb_clear_engine #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .advance   (clear_advance),
        .active    (clear_active),
        .ptr       (clr_ptr),
        .last      (clr_last),
        .done      (clear_done)
    );
`else
    logic unused_clear;
    assign unused_clear = clear_req ^ clear_advance;
    assign clear_active = 1'b0;
    assign clr_ptr      = '0;
    assign clr_last     = 1'b0;
    assign clear_done   = 1'b0;
`endif

endmodule

// File: tb/tb_fb_mem_scheduler.sv
// Directed bench for fb_mem_scheduler with a behavioural 3-plane RAM and write FIFO.
module tb_fb_mem_scheduler;

    localparam int unsigned MEMORY_H  = 80;
    localparam int unsigned WORD_ROWS = 60;
    localparam int unsigned DW        = 6;
    localparam int unsigned AW        = 13;
    localparam int unsigned RDL       = 2;
    localparam int unsigned DEPTH     = MEMORY_H * WORD_ROWS;
    localparam int unsigned SW        = 3;
    localparam int unsigned WAIT_MAX  = 5000;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic [2:0]    rgb;
    } fifo_ent_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic [2:0]    rgb;
        logic [DW-1:0] ir, ig, ib;
        logic [DW-1:0] er, eg, eb;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset, display_on, clear_req;
    logic [AW-1:0] disp_addr;
    logic          fifo_empty, fifo_rd_en;
    logic [AW-1:0] f_addr = '0;
    logic [SW-1:0] f_sel  = '0;
    logic [2:0]    f_rgb  = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we, busy, clear_done;
    logic [DW-1:0] wd_r, wd_g, wd_b, rd_r, rd_g, rd_b;
    logic [7:0]    err_count;

    logic [DW-1:0] ram_r [DEPTH];
    logic [DW-1:0] ram_g [DEPTH];
    logic [DW-1:0] ram_b [DEPTH];
    int unsigned   wr_count [DEPTH];
    logic [DW-1:0] pipe_r [RDL];
    logic [DW-1:0] pipe_g [RDL];
    logic [DW-1:0] pipe_b [RDL];

    fifo_ent_t     fifo_mem [1024];
    int            wp = 0;
    int            rp = 0;

    logic          pre_en = 1'b0;
    logic          cnt_clear = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_r = '0, pre_g = '0, pre_b = '0;
    int            we_viol = 0, rd_viol = 0, done_cnt = 0, total_we = 0;

    int            errors = 0;
    int            checks = 0;
    vec_t          vecs [5];

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);
    assign rd_r = pipe_r[RDL-1];
    assign rd_g = pipe_g[RDL-1];
    assign rd_b = pipe_b[RDL-1];

    fb_mem_scheduler #(
        .MEMORY_H   (MEMORY_H),
        .WORD_ROWS  (WORD_ROWS),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (RDL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .display_on  (display_on),
        .disp_addr   (disp_addr),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_addr   (f_addr),
        .fifo_bitsel (f_sel),
        .fifo_rgb    (f_rgb),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata_r (wd_r),
        .mem_wdata_g (wd_g),
        .mem_wdata_b (wd_b),
        .mem_rdata_r (rd_r),
        .mem_rdata_g (rd_g),
        .mem_rdata_b (rd_b),
        .busy        (busy),
        .err_count   (err_count),
        .clear_req   (clear_req),
        .clear_done  (clear_done)
    );

    // RAM planes with RDL-cycle read pipeline, FIFO read side, protocol monitors.
    always @(posedge clk) begin
        if (pre_en) begin
            ram_r[pre_addr] <= pre_r;
            ram_g[pre_addr] <= pre_g;
            ram_b[pre_addr] <= pre_b;
        end
        if (cnt_clear) begin
            for (int i = 0; i < int'(DEPTH); i++) wr_count[i] <= 0;
        end
        if (mem_we) begin
            total_we <= total_we + 1;
            if (display_on) we_viol <= we_viol + 1;
            if (32'(mem_addr) < DEPTH) begin
                ram_r[mem_addr]    <= wd_r;
                ram_g[mem_addr]    <= wd_g;
                ram_b[mem_addr]    <= wd_b;
                wr_count[mem_addr] <= wr_count[mem_addr] + 1;
            end
        end
        pipe_r[0] <= (32'(mem_addr) < DEPTH) ? ram_r[mem_addr] : '0;
        pipe_g[0] <= (32'(mem_addr) < DEPTH) ? ram_g[mem_addr] : '0;
        pipe_b[0] <= (32'(mem_addr) < DEPTH) ? ram_b[mem_addr] : '0;
        for (int i = 1; i < int'(RDL); i++) begin
            pipe_r[i] <= pipe_r[i-1];
            pipe_g[i] <= pipe_g[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
        if (fifo_rd_en) begin
            if (wp == rp) begin
                rd_viol <= rd_viol + 1;
            end else begin
                f_addr <= fifo_mem[rp].addr;
                f_sel  <= fifo_mem[rp].sel;
                f_rgb  <= fifo_mem[rp].rgb;
                rp     <= rp + 1;
            end
        end
        if (clear_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int a, input int s, input int c);
        fifo_mem[wp].addr = AW'(a);
        fifo_mem[wp].sel  = SW'(s);
        fifo_mem[wp].rgb  = 3'(c);
        wp++;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] r, input logic [DW-1:0] g,
                           input logic [DW-1:0] b);
        pre_addr = AW'(a);
        pre_r    = r;
        pre_g    = g;
        pre_b    = b;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(wp == rp && !busy) && n < int'(WAIT_MAX)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= int'(WAIT_MAX)) begin
            errors++;
            $display("FAIL %s: timeout, busy=%0b fifo_level=%0d, expected idle", name, busy, wp - rp);
        end
    endtask

    task automatic wait_pop(input string name);
        int n = 0;
        while (!fifo_rd_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s: timeout, fifo_rd_en=%0b, expected 1", name, fifo_rd_en);
        end
    endtask

    task automatic check_word(input string name, input int a, input logic [DW-1:0] r,
                              input logic [DW-1:0] g, input logic [DW-1:0] b);
        check({name, ".r"}, 32'(ram_r[a]), 32'(r));
        check({name, ".g"}, 32'(ram_g[a]), 32'(g));
        check({name, ".b"}, 32'(ram_b[a]), 32'(b));
    endtask

    initial begin
        int busy_low;
        int bad;

        vecs[0] = '{addr: 13'd5,    sel: 3'd2, rgb: 3'b010, ir: 6'h3F, ig: 6'h3F, ib: 6'h3F,
                    er: 6'h3B, eg: 6'h3F, eb: 6'h3B};
        vecs[1] = '{addr: 13'd0,    sel: 3'd0, rgb: 3'b111, ir: 6'h00, ig: 6'h00, ib: 6'h00,
                    er: 6'h01, eg: 6'h01, eb: 6'h01};
        vecs[2] = '{addr: 13'd4799, sel: 3'd5, rgb: 3'b100, ir: 6'h00, ig: 6'h3F, ib: 6'h15,
                    er: 6'h20, eg: 6'h1F, eb: 6'h15};
        vecs[3] = '{addr: 13'd100,  sel: 3'd3, rgb: 3'b011, ir: 6'h2A, ig: 6'h2A, ib: 6'h2A,
                    er: 6'h22, eg: 6'h2A, eb: 6'h2A};
        vecs[4] = '{addr: 13'd4720, sel: 3'd4, rgb: 3'b001, ir: 6'h15, ig: 6'h15, ib: 6'h15,
                    er: 6'h05, eg: 6'h05, eb: 6'h15};

        reset      = 1'b1;
        display_on = 1'b0;
        clear_req  = 1'b0;
        disp_addr  = '0;
        repeat (3) @(negedge clk);
        check("rst.fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst.mem_we",     32'(mem_we),     32'd0);
        check("rst.busy",       32'(busy),       32'd0);
        check("rst.err_count",  32'(err_count),  32'd0);
        check("rst.clear_done", 32'(clear_done), 32'd0);
        check("rst.mem_addr",   32'(mem_addr),   32'd0);
        check("rst.wdata_r",    32'(wd_r),       32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single read-modify-writes in blanking.
        for (int v = 0; v < 5; v++) begin
            preload(int'(vecs[v].addr), vecs[v].ir, vecs[v].ig, vecs[v].ib);
            push(int'(vecs[v].addr), int'(vecs[v].sel), int'(vecs[v].rgb));
            wait_idle($sformatf("vec%0d.done", v));
            check_word($sformatf("vec%0d", v), int'(vecs[v].addr), vecs[v].er, vecs[v].eg, vecs[v].eb);
            check($sformatf("vec%0d.wr_count", v), wr_count[vecs[v].addr], 32'd1);
        end

        // Back-to-back writes to one word.
        preload(200, 6'h00, 6'h00, 6'h00);
        push(200, 1, 7);
        push(200, 4, 6);
        wait_idle("same_addr.done");
        check_word("same_addr", 200, 6'h12, 6'h12, 6'h02);
        check("same_addr.wr_count", wr_count[200], 32'd2);

        // Active video: port belongs to scan-out, no pops.
        for (int i = 0; i < 4; i++) preload(300 + i, 6'h00, 6'h00, 6'h00);
        display_on = 1'b1;
        for (int i = 0; i < 4; i++) push(300 + i, 0, 7);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            disp_addr = AW'($urandom_range(0, DEPTH - 1));
            #1;
            check("video.fifo_rd_en", 32'(fifo_rd_en), 32'd0);
            check("video.mem_we",     32'(mem_we),     32'd0);
            check("video.mem_addr",   32'(mem_addr),   32'(disp_addr));
        end
        @(negedge clk);
        display_on = 1'b0;
        wait_idle("video_drain.done");
        for (int i = 0; i < 4; i++) check_word($sformatf("video_drain%0d", i), 300 + i, 6'h01, 6'h01, 6'h01);

        // Video starts while the read is in flight: entry held, written once later.
        preload(400, 6'h00, 6'h00, 6'h00);
        push(400, 1, 2);
        wait_pop("abort.pop");
        repeat (2) @(negedge clk);
        display_on = 1'b1;
        busy_low = 0;
        repeat (30) begin
            @(negedge clk);
            if (!busy) busy_low++;
        end
        check("abort.busy_low_cycles", 32'(busy_low), 32'd0);
        check("abort.no_write_in_video", wr_count[400], 32'd0);
        display_on = 1'b0;
        wait_idle("abort.done");
        check_word("abort", 400, 6'h00, 6'h02, 6'h00);
        check("abort.wr_count", wr_count[400], 32'd1);

        // Out-of-range entries are discarded and counted, saturating at 255.
        preload(7, 6'h15, 6'h15, 6'h15);
        push(int'(DEPTH), 0, 7);
        push(7, 6, 7);
        wait_idle("range.done");
        check("range.err_count", 32'(err_count), 32'd2);
        check("range.word_kept", 32'(ram_r[7]), 32'h15);
        check("range.wr_count", wr_count[7], 32'd0);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) push(int'(DEPTH) + i, 0, 5);
            else            push(i, 7, 5);
        end
        wait_idle("saturate.done");
        check("saturate.err_count", 32'(err_count), 32'd255);

        // Reset in MERGE drops the held entry.
        preload(500, 6'h00, 6'h00, 6'h00);
        push(500, 0, 7);
        wait_pop("rst_merge.pop");
        repeat (2 + RDL) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_merge.mem_we",     32'(mem_we),     32'd0);
        check("rst_merge.busy",       32'(busy),       32'd0);
        check("rst_merge.err_count",  32'(err_count),  32'd0);
        check("rst_merge.fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_merge.mem_addr",   32'(mem_addr),   32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_merge.wr_count", wr_count[500], 32'd0);
        check("rst_merge.busy_after", 32'(busy), 32'd0);

`ifdef FB_CLEAR_EN
        // Full clear with video interrupting it and a repeated request mid-clear.
        for (int a = 0; a < int'(DEPTH); a++) preload(a, 6'h2A, 6'h15, 6'h3F);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        begin
            int n = 0;
            while (done_cnt == 0 && n < 30000) begin
                @(negedge clk);
                n++;
                if (n % 37 == 0) display_on = ~display_on;
                clear_req = (n == 1000);
            end
            checks++;
            if (n >= 30000) begin
                errors++;
                $display("FAIL clear.timeout: clear_done never seen, expected one pulse");
            end
        end
        display_on = 1'b0;
        clear_req  = 1'b0;
        repeat (50) @(negedge clk);
        check("clear.done_pulses", 32'(done_cnt), 32'd1);
        bad = 0;
        for (int a = 0; a < int'(DEPTH); a++)
            if (wr_count[a] != 1 || ram_r[a] != 0 || ram_g[a] != 0 || ram_b[a] != 0) bad++;
        check("clear.bad_words", 32'(bad), 32'd0);
        check("clear.busy_after", 32'(busy), 32'd0);
`else
        begin
            int we_before;
            we_before = total_we;
            clear_req = 1'b1;
            @(negedge clk);
            clear_req = 1'b0;
            repeat (50) @(negedge clk);
            check("noclear.done_pulses", 32'(done_cnt), 32'd0);
            check("noclear.writes", 32'(total_we - we_before), 32'd0);
            check("noclear.busy", 32'(busy), 32'd0);
        end
`endif

        check("mon.we_during_video", 32'(we_viol), 32'd0);
        check("mon.pop_when_empty",  32'(rd_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
